// File: rtl/nn_fp_pkg.sv
// Shared float32 definitions for the neural-network datapath stages
// (dense MAC, tansig, and later sigmoid/relu).
`timescale 1ns/1ps
package nn_fp_pkg;

  localparam int FLOAT   = 32;
  localparam int CNT_W   = 10;
  localparam int FMA_LAT = 8;

  localparam logic [FLOAT-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FLOAT-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_FMA = 2'd2,
    ST_DONE     = 2'd3
  } mac_state_e;

endpackage

// File: rtl/fp_mul_add.sv
// Fixed-latency float32 fused multiply-add a*b+c, round-to-nearest-even.
// Stream-style wrapper: i_tvalid enters with the operands, o_tvalid comes
// out LAT cycles later. The product is kept exact and rounded only once.
`timescale 1ns/1ps
module fp_mul_add
  import nn_fp_pkg::*;
#(
  parameter int LAT = FMA_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tvalid,
  input  logic [FLOAT-1:0] i_a,
  input  logic [FLOAT-1:0] i_b,
  input  logic [FLOAT-1:0] i_c,
  output logic             o_tvalid,
  output logic [FLOAT-1:0] o_tdata
);

  // Leading-zero count of a 52-bit word (52 when the word is zero).
  function automatic int lzc52(input logic [51:0] v);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = 51; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 1;
      end
    end
    return n;
  endfunction

  // Single-rounding a*b+c. Both addends are normalised to a 48-bit
  // significand plus 3 guard bits, the smaller one is aligned with a
  // sticky bit, and the sum is normalised and rounded once.
  function automatic logic [31:0] fma_f32(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    logic        sp, sc, big_s, sm_s, r_s, stk, den, g, st, up;
    logic        a_nan, b_nan, c_nan, a_inf, b_inf, c_inf;
    logic        a_zero, b_zero, c_zero;
    logic [23:0] ma, mb, mc, m24;
    logic [24:0] m25;
    logic [47:0] pm, yv;
    logic [50:0] xw, yw, bw, sw, ssh;
    logic [51:0] s, sn;
    int          ea, eb, ec, ex, ey, e_big, d, lz, re, sh, eo;
    logic [31:0] res;

    sp     = a[31] ^ b[31];
    sc     = c[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    c_nan  = (c[30:23] == 8'hFF) && (c[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    c_inf  = (c[30:23] == 8'hFF) && (c[22:0] == 23'h0);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    c_zero = (c[30:0] == 31'h0);

    // Denormals use the hidden bit 0 and the minimum exponent 1.
    ma = {(a[30:23] != 8'h00), a[22:0]};
    mb = {(b[30:23] != 8'h00), b[22:0]};
    mc = {(c[30:23] != 8'h00), c[22:0]};
    ea = (a[30:23] == 8'h00) ? 32'sd1 : int'(a[30:23]);
    eb = (b[30:23] == 8'h00) ? 32'sd1 : int'(b[30:23]);
    ec = (c[30:23] == 8'h00) ? 32'sd1 : int'(c[30:23]);

    res = FP_ZERO;
    if (a_nan || b_nan || c_nan || (a_inf && b_zero) || (b_inf && a_zero) ||
        ((a_inf || b_inf) && c_inf && (sp != sc))) begin
      res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      res = {sp, 8'hFF, 23'h0};
    end else if (c_inf) begin
      res = c;
    end else if ((a_zero || b_zero) && c_zero) begin
      res = {sp & sc, 31'h0};
    end else begin
      // Exact product, left-justified; exponent is that of bit 3 of xw.
      pm = 48'(ma) * 48'(mb);
      if (pm == 48'h0) begin
        xw = '0;
        ex = -32'sd100000;
      end else begin
        lz = lzc52({pm, 4'h0});
        xw = {pm << lz, 3'b000};
        ex = ea + eb - 32'sd300 - lz;
      end
      yv = {mc, 24'h0};
      if (c_zero) begin
        yw = '0;
        ey = -32'sd100000;
      end else begin
        lz = lzc52({yv, 4'h0});
        yw = {yv << lz, 3'b000};
        ey = ec - 32'sd174 - lz;
      end

      if (ex >= ey) begin
        bw = xw; big_s = sp; e_big = ex; sw = yw; sm_s = sc; d = ex - ey;
      end else begin
        bw = yw; big_s = sc; e_big = ey; sw = xw; sm_s = sp; d = ey - ex;
      end

      if (d >= 32'sd51) begin
        ssh = '0;
        stk = |sw;
      end else begin
        ssh = sw >> d;
        stk = |(sw & ((51'd1 << d) - 51'd1));
      end
      ssh[0] = ssh[0] | stk;

      if (big_s == sm_s) begin
        s = {1'b0, bw} + {1'b0, ssh}; r_s = big_s;
      end else if (ssh > bw) begin
        s = {1'b0, ssh} - {1'b0, bw}; r_s = sm_s;
      end else begin
        s = {1'b0, bw} - {1'b0, ssh}; r_s = big_s;
      end

      if (s == 52'h0) begin
        res = FP_ZERO;
      end else begin
        lz  = lzc52(s);
        sn  = s << lz;
        re  = e_big + 32'sd175 - lz;
        den = 1'b0;
        stk = 1'b0;
        // Result below the normal range: shift into denormal position.
        if (re <= 32'sd0) begin
          den = 1'b1;
          sh  = 32'sd1 - re;
          if (sh >= 32'sd52) begin
            stk = |sn;
            sn  = '0;
          end else begin
            stk = |(sn & ((52'd1 << sh) - 52'd1));
            sn  = sn >> sh;
          end
        end
        m24 = sn[51:28];
        g   = sn[27];
        st  = (|sn[26:0]) | stk;
        up  = g & (st | m24[0]);
        m25 = {1'b0, m24} + {24'h0, up};
        if (den) begin
          eo = m25[23] ? 32'sd1 : 32'sd0;
        end else if (m25[24]) begin
          eo = re + 32'sd1;
        end else begin
          eo = re;
        end
        if (eo >= 32'sd255) res = {r_s, 8'hFF, 23'h0};
        else                res = {r_s, eo[7:0], m25[22:0]};
      end
    end
    return res;
  endfunction

  logic [LAT-1:0]   r_vld;
  logic [FLOAT-1:0] r_dat [LAT];
  logic [FLOAT-1:0] w_result;

  assign w_result = fma_f32(i_a, i_b, i_c);

  // Delay line giving the fixed latency; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_dat[i] <= FP_ZERO;
    end else begin
      r_vld    <= {r_vld[LAT-2:0], i_tvalid};
      r_dat[0] <= w_result;
      for (int i = 1; i < LAT; i++) r_dat[i] <= r_dat[i-1];
    end
  end

  assign o_tvalid = r_vld[LAT-1];
  assign o_tdata  = r_dat[LAT-1];

endmodule

// File: rtl/dense_neuron_mac.sv
// Single-neuron dense-layer accumulator: bias + sum(x[i]*w[i]) in float32,
// one fused multiply-add in flight at a time, result held until accepted.
`timescale 1ns/1ps
module dense_neuron_mac
  import nn_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FLOAT-1:0] bias,
  input  logic [CNT_W-1:0] n_inputs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLOAT-1:0] in_x,
  input  logic [FLOAT-1:0] in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLOAT-1:0] out_data,
  output logic             busy
);

  mac_state_e       r_state, w_next_state;
  logic [FLOAT-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, r_n, w_n_next, w_cnt_inc;
  logic             r_in_ready, r_out_valid, r_busy;
  logic [FLOAT-1:0] r_out_data;
  logic             w_fma_issue, w_fma_vld;
  logic [FLOAT-1:0] w_fma_res;

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  fp_mul_add #(.LAT(FMA_LAT)) u_fma (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tvalid (w_fma_issue),
    .i_a      (in_x),
    .i_b      (in_w),
    .i_c      (r_acc),
    .o_tvalid (w_fma_vld),
    .o_tdata  (w_fma_res)
  );

  // Next-state and next-datapath decode for the neuron sequencer.
  always_comb begin
    w_next_state = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_n_next     = r_n;
    w_fma_issue  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_next   = bias;
          w_n_next     = n_inputs;
          w_cnt_next   = '0;
          w_next_state = (n_inputs == '0) ? ST_DONE : ST_WAIT_IN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid && r_in_ready) begin
          w_fma_issue  = 1'b1;
          w_next_state = ST_WAIT_FMA;
        end else begin
          w_next_state = ST_WAIT_IN;
        end
      end
      ST_WAIT_FMA: begin
        // Terminal compare uses the incremented count, so cnt never wraps.
        if (w_fma_vld) begin
          w_acc_next   = w_fma_res;
          w_cnt_next   = w_cnt_inc;
          w_next_state = (w_cnt_inc == r_n) ? ST_DONE : ST_WAIT_IN;
        end else begin
          w_next_state = ST_WAIT_FMA;
        end
      end
      ST_DONE: begin
        if (out_ready) w_next_state = ST_IDLE;
        else           w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, accumulator and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= FP_ZERO;
      r_cnt   <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_n     <= w_n_next;
    end
  end

  // Outputs registered from the next state so they line up with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= FP_ZERO;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == ST_WAIT_IN);
      r_out_valid <= (w_next_state == ST_DONE);
      r_out_data  <= (w_next_state == ST_DONE) ? w_acc_next : FP_ZERO;
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
